pong_pixel_gen: RTL and testbench

Parametrised pixel generator for the motion-controlled pong display. It sits between the VGA sync counter and the RGB pins. It renders the border, a paddle centred on the motion-sensor `display_x`, and a ball that moves once per frame. Unlike the static-ball generator, it owns the ball physics: a serve/play/miss state machine, wall and paddle bounces, and a miss counter.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_pixel_gen_if.sv | 10 +
 rtl/pong_ball_fsm.sv | 99 +++++++++
 rtl/pong_pixel_gen.sv | 52 +++++
 tb/tb_pong_pixel_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, default geometry and colour codes shared by the pong pixel generator.
package pong_pkg;
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;
  typedef logic [2:0] rgb_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PADDLE_W_DEF = 100;
  localparam int PADDLE_H_DEF = 20;
  localparam int PADDLE_TOP_DEF = 450;
  localparam int BALL_SIZE_DEF = 20;
  localparam int BALL_STEP_DEF = 2;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int COLOR_W_DEF = 4;
  localparam rgb_t WHITE = 3'b111;
  localparam rgb_t CYAN = 3'b011;
  localparam rgb_t RED = 3'b100;
  localparam rgb_t BLACK = 3'b000;
endpackage

// File: rtl/pong_pixel_gen_if.sv
// pong_pixel_gen_if: sync-counter/sensor inputs and colour/status outputs of the pong pixel generator.
interface pong_pixel_gen_if #(parameter int COLOR_W = 4);
  logic [9:0] pixel_x, pixel_y, display_x;
  logic video_on;
  logic [COLOR_W-1:0] red, green, blue;
  logic [1:0] game_state;
  logic [7:0] miss_count;
  modport master (output pixel_x, pixel_y, video_on, display_x, input red, green, blue, game_state, miss_count);
  modport slave (input pixel_x, pixel_y, video_on, display_x, output red, green, blue, game_state, miss_count);
endinterface

// File: rtl/pong_ball_fsm.sv
// pong_ball_fsm: serve/play/miss ball physics, advanced only on the frame tick.
module pong_ball_fsm
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PADDLE_TOP = PADDLE_TOP_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int BALL_STEP = BALL_STEP_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic [10:0] pad_l_i,
  input  logic [10:0] pad_r_i,
  output logic [10:0] ball_x_o,
  output logic [10:0] ball_y_o,
  output state_t      state_o,
  output logic [7:0]  miss_count_o
);
  localparam logic [10:0] STP = 11'(BALL_STEP);
  localparam logic [10:0] SZ = 11'(BALL_SIZE);
  localparam logic [10:0] X0 = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] Y0 = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - 1 - BALL_SIZE);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - 1 - BALL_SIZE);
  localparam logic [10:0] HM1 = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VM1 = 11'(V_ACTIVE - 1);
  localparam logic [10:0] PT = 11'(PADDLE_TOP);
  state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d, nx, ny;
  logic dx_q, dx_d, dy_q, dy_d, ndx, ndy, hit, miss;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] miss_q, miss_d;
  // a paddle hit wins over the miss test so a last-moment save still bounces
  assign hit = dy_q && y_q + SZ >= PT - STP && y_q + SZ <= PT && x_q < pad_r_i && x_q + SZ > pad_l_i;
  assign miss = !hit && y_q + SZ >= VM1;
  assign ndx = x_q + SZ + STP >= HM1 ? 1'b0 : x_q <= STP + 11'd1 ? 1'b1 : dx_q;
  assign ndy = hit ? 1'b0 : y_q <= STP + 11'd1 ? 1'b1 : dy_q;
  assign nx = ndx ? (x_q + STP > XMAX ? XMAX : x_q + STP) : (x_q <= STP ? 11'd1 : x_q - STP);
  assign ny = ndy ? (y_q + STP > YMAX ? YMAX : y_q + STP) : (y_q <= STP ? 11'd1 : y_q - STP);
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    if (tick_i) begin
      case (state_q)
        SERVE: begin
          state_d = cnt_q == 16'(SERVE_FRAMES - 1) ? PLAY : SERVE;
          cnt_d = cnt_q == 16'(SERVE_FRAMES - 1) ? 16'd0 : cnt_q + 16'd1;
        end
        PLAY: begin
          dx_d = ndx;
          dy_d = ndy;
          x_d = nx;
          y_d = ny;
          state_d = miss ? MISS : PLAY;
          miss_d = miss ? miss_q + 8'(miss_q != 8'hFF) : miss_q;
        end
        MISS: begin
          state_d = SERVE;
          x_d = X0;
          y_d = Y0;
          dx_d = !dx_q;
          dy_d = 1'b0;
        end
        default: state_d = SERVE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SERVE;
      x_q <= X0;
      y_q <= Y0;
      dx_q <= 1'b1;
      dy_q <= 1'b0;
      cnt_q <= 16'd0;
      miss_q <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
    end
  end
  assign ball_x_o = x_q;
  assign ball_y_o = y_q;
  assign state_o = state_q;
  assign miss_count_o = miss_q;
endmodule

// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: frame tick, paddle edges and registered border/ball/paddle colour mux.
module pong_pixel_gen
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PADDLE_W = PADDLE_W_DEF,
  parameter int PADDLE_H = PADDLE_H_DEF,
  parameter int PADDLE_TOP = PADDLE_TOP_DEF,
  parameter int BALL_SIZE = BALL_SIZE_DEF,
  parameter int BALL_STEP = BALL_STEP_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input logic             clk,
  input logic             reset,
  pong_pixel_gen_if.slave bus
);
  localparam logic [10:0] HALF = 11'(PADDLE_W / 2);
  localparam logic [10:0] HM1 = 11'(H_ACTIVE - 1);
  localparam logic [10:0] VM1 = 11'(V_ACTIVE - 1);
  localparam logic [10:0] PT = 11'(PADDLE_TOP);
  localparam logic [10:0] PB = 11'(PADDLE_TOP + PADDLE_H);
  localparam logic [10:0] SZ = 11'(BALL_SIZE);
  logic [10:0] px, py, dsp, pad_l, pad_r, bx, by;
  logic tick, border, in_ball, in_pad;
  state_t state;
  rgb_t rgb_d, rgb_q;
  assign px = {1'b0, bus.pixel_x};
  assign py = {1'b0, bus.pixel_y};
  assign dsp = {1'b0, bus.display_x};
  assign tick = bus.pixel_x == 10'd0 && bus.pixel_y == 10'(V_ACTIVE);
  // saturate both edges so a paddle near either wall never wraps
  assign pad_l = dsp < HALF ? 11'd0 : dsp - HALF;
  assign pad_r = dsp + HALF > HM1 ? HM1 : dsp + HALF;
  pong_ball_fsm #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .PADDLE_TOP(PADDLE_TOP),
    .BALL_SIZE(BALL_SIZE), .BALL_STEP(BALL_STEP), .SERVE_FRAMES(SERVE_FRAMES)
  ) u_ball (
    .clk(clk), .reset(reset), .tick_i(tick), .pad_l_i(pad_l), .pad_r_i(pad_r),
    .ball_x_o(bx), .ball_y_o(by), .state_o(state), .miss_count_o(bus.miss_count)
  );
  assign border = px == 11'd0 || px == HM1 || py == 11'd0 || py == VM1;
  assign in_ball = px >= bx && px < bx + SZ && py >= by && py < by + SZ;
  assign in_pad = px >= pad_l && px < pad_r && py >= PT && py < PB;
  always_comb rgb_d = !bus.video_on ? BLACK : border ? WHITE : in_ball ? (state == MISS ? RED : CYAN) : in_pad ? CYAN : BLACK;
  always_ff @(posedge clk) rgb_q <= reset ? BLACK : rgb_d;
  assign bus.red = {COLOR_W{rgb_q[2]}};
  assign bus.green = {COLOR_W{rgb_q[1]}};
  assign bus.blue = {COLOR_W{rgb_q[0]}};
  assign bus.game_state = state;
endmodule

// File: tb/tb_pong_pixel_gen.sv
// tb_pong_pixel_gen: directed probes and frame ticks; expectations queued and checked by a monitor.
module tb_pong_pixel_gen;
  import pong_pkg::*;
  typedef struct {
    string name;
    int kind;
    logic [11:0] exp;
  } item_t;
  logic clk = 1'b0, reset = 1'b1, f_reset = 1'b1, req = 1'b0, vq = 1'b0;
  logic [9:0] dsp = 10'd600;
  int ncmp = 0, nfail = 0;
  item_t q[$];
  item_t it;
  logic [11:0] act;
  pong_pixel_gen_if #(.COLOR_W(4)) bus ();
  pong_pixel_gen_if #(.COLOR_W(4)) fbus ();
  pong_pixel_gen dut (.clk(clk), .reset(reset), .bus(bus));
  // fast variant: no reachable paddle, big step, short serve -> 20 ticks per miss
  pong_pixel_gen #(.PADDLE_W(2), .BALL_STEP(40), .SERVE_FRAMES(2)) fdut (.clk(clk), .reset(f_reset), .bus(fbus));
  always #5 clk = ~clk;
  always @(posedge clk) vq <= req;
  always @(negedge clk) begin
    if (vq) begin
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        it = q.pop_front();
        act = it.kind == 0 ? {bus.red, bus.green, bus.blue} : it.kind == 1 ? {10'd0, bus.game_state} :
              it.kind == 2 ? {4'd0, bus.miss_count} : {4'd0, fbus.miss_count};
        ncmp++;
        if (act !== it.exp) begin
          nfail++;
          $display("FAIL %s: got %03h, want %03h", it.name, act, it.exp);
        end
      end
    end
  end
  function automatic logic [11:0] col(input rgb_t c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction
  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic v, input logic r);
    @(posedge clk);
    #1;
    bus.pixel_x = x;
    bus.pixel_y = y;
    bus.video_on = v;
    bus.display_x = dsp;
    req = r;
  endtask
  task automatic push(input int k, input logic [11:0] e, input string n);
    q.push_back('{name: n, kind: k, exp: e});
  endtask
  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic v, input rgb_t c, input string n);
    drive(x, y, v, 1'b1);
    push(0, col(c), n);
  endtask
  task automatic check_state(input state_t s, input string n);
    drive(10'd1, 10'd1, 1'b0, 1'b1);
    push(1, 12'(s), n);
  endtask
  task automatic check_count(input int c, input string n);
    drive(10'd1, 10'd1, 1'b0, 1'b1);
    push(2, 12'(c), n);
  endtask
  task automatic check_fast(input int c, input string n);
    drive(10'd1, 10'd1, 1'b0, 1'b1);
    push(3, 12'(c), n);
  endtask
  task automatic idle();
    drive(10'd1, 10'd1, 1'b0, 1'b0);
  endtask
  task automatic ticks(input int n);
    repeat (n) drive(10'd0, 10'd480, 1'b0, 1'b0);
  endtask
  initial begin
    bus.pixel_x = 10'd1;
    bus.pixel_y = 10'd1;
    bus.video_on = 1'b0;
    bus.display_x = dsp;
    fbus.pixel_x = 10'd0;
    fbus.pixel_y = 10'd480;
    fbus.video_on = 1'b0;
    fbus.display_x = 10'd0;
    probe(10'd0, 10'd100, 1'b1, BLACK, "rgb_in_reset");
    check_state(SERVE, "state_reset");
    check_count(0, "miss_reset");
    idle();
    reset = 1'b0;
    ticks(59);
    check_state(SERVE, "serve_after_59");
    ticks(1);
    check_state(PLAY, "play_on_tick_60");
    probe(10'd310, 10'd230, 1'b1, CYAN, "ball_centre");
    probe(10'd309, 10'd230, 1'b1, BLACK, "left_of_centre");
    ticks(1);
    probe(10'd312, 10'd228, 1'b1, CYAN, "step1_top_left");
    probe(10'd331, 10'd247, 1'b1, CYAN, "step1_bottom_right");
    probe(10'd332, 10'd247, 1'b1, BLACK, "step1_right_edge");
    probe(10'd312, 10'd227, 1'b1, BLACK, "step1_top_edge");
    probe(10'd311, 10'd228, 1'b1, BLACK, "step1_left_edge");
    probe(10'd0, 10'd100, 1'b1, WHITE, "border_left");
    probe(10'd0, 10'd100, 1'b0, BLACK, "border_video_off");
    probe(10'd639, 10'd200, 1'b1, WHITE, "border_right");
    probe(10'd300, 10'd479, 1'b1, WHITE, "border_bottom");
    dsp = 10'd20;
    probe(10'd5, 10'd460, 1'b1, CYAN, "padl_inside");
    probe(10'd69, 10'd460, 1'b1, CYAN, "padl_last_col");
    probe(10'd70, 10'd460, 1'b1, BLACK, "padl_right_edge");
    probe(10'd75, 10'd460, 1'b1, BLACK, "padl_outside");
    probe(10'd0, 10'd460, 1'b1, WHITE, "padl_border_wins");
    probe(10'd5, 10'd450, 1'b1, CYAN, "pad_top_row");
    probe(10'd5, 10'd449, 1'b1, BLACK, "pad_above");
    probe(10'd5, 10'd470, 1'b1, BLACK, "pad_below");
    dsp = 10'd630;
    probe(10'd600, 10'd460, 1'b1, CYAN, "padr_inside");
    probe(10'd638, 10'd460, 1'b1, CYAN, "padr_no_wrap");
    probe(10'd580, 10'd460, 1'b1, CYAN, "padr_left_col");
    probe(10'd579, 10'd460, 1'b1, BLACK, "padr_left_edge");
    probe(10'd5, 10'd460, 1'b1, BLACK, "padr_far_left");
    dsp = 10'd600;
    ticks(342);
    check_state(PLAY, "play_before_miss");
    check_count(0, "count_before_miss");
    ticks(1);
    check_state(MISS, "state_miss");
    check_count(1, "count_after_miss");
    probe(10'd238, 10'd459, 1'b1, RED, "miss_ball_red_tl");
    probe(10'd257, 10'd478, 1'b1, RED, "miss_ball_red_br");
    probe(10'd237, 10'd459, 1'b1, BLACK, "miss_ball_left");
    probe(10'd258, 10'd478, 1'b1, BLACK, "miss_ball_right");
    ticks(1);
    check_state(SERVE, "serve_after_miss");
    check_count(1, "count_held");
    probe(10'd310, 10'd230, 1'b1, CYAN, "recentred");
    probe(10'd238, 10'd459, 1'b1, BLACK, "old_pos_cleared");
    ticks(60);
    check_state(PLAY, "replay");
    ticks(1);
    probe(10'd331, 10'd228, 1'b1, CYAN, "serve_dx_inverted");
    probe(10'd308, 10'd228, 1'b1, BLACK, "serve_not_left");
    probe(10'd311, 10'd228, 1'b1, BLACK, "serve_left_edge");
    idle();
    reset = 1'b1;
    probe(10'd0, 10'd100, 1'b1, BLACK, "rgb_mid_reset");
    check_state(SERVE, "state_mid_reset");
    check_count(0, "count_mid_reset");
    idle();
    reset = 1'b0;
    ticks(387);
    dsp = 10'd310;
    ticks(1);
    dsp = 10'd600;
    check_state(PLAY, "hit_stays_play");
    check_count(0, "hit_no_miss");
    probe(10'd270, 10'd426, 1'b1, CYAN, "bounce_top_left");
    probe(10'd270, 10'd425, 1'b1, BLACK, "bounce_above");
    probe(10'd289, 10'd445, 1'b1, CYAN, "bounce_bottom_right");
    probe(10'd289, 10'd446, 1'b1, BLACK, "bounce_below");
    ticks(1);
    probe(10'd268, 10'd424, 1'b1, CYAN, "rising_top");
    probe(10'd268, 10'd444, 1'b1, BLACK, "rising_bottom");
    idle();
    f_reset = 1'b0;
    repeat (199) idle();
    check_fast(10, "fast_count_10");
    repeat (6000) idle();
    check_fast(255, "fast_saturated");
    idle();
    idle();
    for (int i = 0; i < 8 && q.size() != 0; i++) idle();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
